prs_share_ctrl: RTL and testbench

//  Shares one 8-bit pseudo-random sequence generator between two requesters.
//  It sequences the generator: seed load, N shift steps per word, then a one-cycle grant.

---
 rtl/prs_share_ctrl_pkg.sv | 17 +
 rtl/prs_lfsr_core.sv | 26 ++
 rtl/prs_share_ctrl.sv | 100 ++++++++++
 tb/tb_prs_share_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/prs_share_ctrl_pkg.sv
// rtl/prs_share_ctrl_pkg.sv - shared encodings and constants for the PRS share controller
package prs_share_ctrl_pkg;

    localparam int PRS_WIDTH = 8;
    localparam int TAP_LO    = 2;
    localparam int TAP_HI    = 3;

    // All-ones in the low nibble is the XNOR feedback lock-up state
    localparam logic [3:0] LOCK_MASK = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_GRANT = 2'd2
    } prs_state_e;

endpackage

// File: rtl/prs_lfsr_core.sv
// rtl/prs_lfsr_core.sv - XNOR-feedback shift register with load and step controls
module prs_lfsr_core
    import prs_share_ctrl_pkg::*;
#(
    parameter int               WIDTH    = PRS_WIDTH,
    parameter logic [WIDTH-1:0] SEED_RST = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             STEP,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            Q <= SEED_RST;
        end else if (LOAD) begin
            Q <= LOAD_VAL;
        end else if (STEP) begin
            Q <= {Q[WIDTH-2:0], ~(Q[TAP_LO] ^ Q[TAP_HI])};
        end
    end

endmodule

// File: rtl/prs_share_ctrl.sv
// rtl/prs_share_ctrl.sv - round-robin sharing of one PRS generator between two requesters
module prs_share_ctrl
    import prs_share_ctrl_pkg::*;
#(
    parameter int               WIDTH    = PRS_WIDTH,
    parameter int               STEPS    = 8,
    parameter logic [WIDTH-1:0] SEED_RST = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SEED_LOAD,
    input  logic [WIDTH-1:0] SEED,
    input  logic [1:0]       REQ,
    output logic [1:0]       GNT,
    output logic [WIDTH-1:0] DATA,
    output logic             VALID,
    output logic             BUSY
);

    prs_state_e       state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic             rr;
    logic             owner, owner_nxt;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] g_next;
    logic [WIDTH-1:0] load_val;

    assign load_val = (SEED[3:0] == LOCK_MASK) ? {SEED[WIDTH-1:1], 1'b0} : SEED;

    // Value g takes on the final step edge; DATA is registered from it so the
    // word appears in the same cycle as GNT.
    assign g_next = {g[WIDTH-2:0], ~(g[TAP_LO] ^ g[TAP_HI])};

    prs_lfsr_core #(
        .WIDTH    (WIDTH),
        .SEED_RST (SEED_RST)
    ) u_lfsr (
        .CLK      (CLK),
        .RST      (RST),
        .LOAD     (SEED_LOAD),
        .LOAD_VAL (load_val),
        .STEP     (state == ST_STEP),
        .Q        (g)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        owner_nxt = owner;
        case (state)
            ST_IDLE: begin
                if (REQ != 2'b00) begin
                    owner_nxt = REQ[rr] ? rr : ~rr;
                    cnt_nxt   = '0;
                    state_nxt = ST_STEP;
                end
            end
            ST_STEP: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt == 4'(STEPS - 1)) begin
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        // A seed load discards whatever word was in flight
        if (SEED_LOAD) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            cnt   <= '0;
            rr    <= 1'b0;
            owner <= 1'b0;
            GNT   <= 2'b00;
            VALID <= 1'b0;
            DATA  <= '0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            owner <= owner_nxt;
            BUSY  <= (state_nxt != ST_IDLE);
            VALID <= (state_nxt == ST_GRANT);
            GNT   <= (state_nxt == ST_GRANT) ? (2'b01 << owner) : 2'b00;
            if (state_nxt == ST_GRANT) begin
                DATA <= g_next;
            end
            if (state == ST_GRANT) begin
                rr <= ~owner;
            end
        end
    end

endmodule

// File: tb/tb_prs_share_ctrl.sv
// tb/tb_prs_share_ctrl.sv - randomized scoreboard bench for prs_share_ctrl
module tb_prs_share_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       SEED_LOAD;
    logic [7:0] SEED;
    logic [1:0] REQ;
    logic [1:0] GNT;
    logic [7:0] DATA;
    logic       VALID;
    logic       BUSY;

    always #5 CLK = ~CLK;

    prs_share_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .SEED_LOAD (SEED_LOAD),
        .SEED      (SEED),
        .REQ       (REQ),
        .GNT       (GNT),
        .DATA      (DATA),
        .VALID     (VALID),
        .BUSY      (BUSY)
    );

    typedef struct packed {
        logic [1:0] gnt;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    logic [7:0] m_g;
    logic       m_rr;
    logic [7:0] m_last;
    logic [1:0] req_v;
    logic       winner;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Eight generator steps computed arithmetically: shift left, new bit = NOT(bit2 XOR bit3)
    function automatic logic [7:0] ref_word(input logic [7:0] v);
        int x = int'(v);
        for (int i = 0; i < 8; i++) begin
            x = ((x * 2) % 256) + (1 - (((x / 4) % 2) ^ ((x / 8) % 2)));
        end
        return 8'(x);
    endfunction

    function automatic logic [7:0] seed_fix(input logic [7:0] s);
        return (int'(s) % 16 == 15) ? s - 8'd1 : s;
    endfunction

    // Called at the negedge just before the DUT samples REQ in IDLE
    task automatic predict();
        exp_t e;
        winner = req_v[m_rr] ? m_rr : ~m_rr;
        m_g    = ref_word(m_g);
        e.gnt  = winner ? 2'b10 : 2'b01;
        e.data = m_g;
        exp_q.push_back(e);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  BUSY,  1'b0);
        check({tag, "_valid"}, VALID, 1'b0);
        check({tag, "_data"},  DATA,  m_last);
    endtask

    // mode 0: plain, 1: seed load after k cycles, 2: reset after k cycles
    task automatic serve(input int mode, input int k, input logic [7:0] seed);
        int lat;
        bit got;
        if (mode != 0) begin
            if (k > 0) begin
                predict();
                repeat (k) @(negedge CLK);
                if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
            end
            if (mode == 1) begin
                SEED      = seed;
                SEED_LOAD = 1'b1;
                m_g       = seed_fix(seed);
            end else begin
                RST  = 1'b1;
                exp_q.delete();
                m_g  = 8'h00;
                m_rr = 1'b0;
                m_last = 8'h00;
            end
            @(negedge CLK);
            SEED_LOAD = 1'b0;
            RST       = 1'b0;
            check("abort_busy", BUSY, 1'b0);
            check("abort_gnt",  GNT,  2'b00);
            check("abort_data", DATA, m_last);
        end
        predict();
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            @(negedge CLK);
            lat++;
            if (lat <= 9) check("busy_in_op", BUSY, 1'b1);
            if (GNT != 2'b00) got = 1;
        end
        check("grant_latency", lat, 9);
        m_rr   = ~winner;
        m_last = m_g;
        @(negedge CLK);
        check_idle("post_grant");
    endtask

    task automatic do_reset();
        RST    = 1'b1;
        REQ    = 2'b00;
        req_v  = 2'b00;
        exp_q.delete();
        m_g    = 8'h00;
        m_rr   = 1'b0;
        m_last = 8'h00;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    // Monitor: pops and compares whenever the DUT presents a grant
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (GNT !== 2'b00 || VALID !== 1'b0) begin
                check("valid_vs_gnt", VALID, (GNT != 2'b00));
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_grant: got gnt=%b data=%h, expected no grant", GNT, DATA);
                end else begin
                    e = exp_q.pop_front();
                    check("gnt",  GNT,  e.gnt);
                    check("data", DATA, e.data);
                end
            end
        end
    end

    initial begin
        int mode;
        int k;
        logic [7:0] s;
        RST = 1'b1; SEED_LOAD = 1'b0; SEED = 8'h00; REQ = 2'b00;
        req_v = 2'b00; m_g = 8'h00; m_rr = 1'b0; m_last = 8'h00; winner = 1'b0;
        @(negedge CLK);
        do_reset();
        check("rst_gnt", GNT, 2'b00);
        check_idle("rst");

        // Two back-to-back words for requester 0: EC then A1
        req_v = 2'b01; REQ = req_v; serve(0, 0, 8'h00);
        REQ = req_v; serve(0, 0, 8'h00);

        // Both held: strict alternation
        do_reset();
        req_v = 2'b11; REQ = req_v;
        repeat (4) serve(0, 0, 8'h00);

        // Lock-up guarded seed together with a request
        req_v = 2'b10; REQ = req_v; serve(1, 0, 8'h0F);

        // Seed load mid-step, then reset just before grant
        do_reset();
        req_v = 2'b01; REQ = req_v; serve(1, 4, 8'h00);
        REQ = req_v; serve(2, 8, 8'h00);

        for (int it = 0; it < 60; it++) begin
            req_v[winner] = ($urandom_range(0, 2) == 0);
            if (!req_v[~winner]) req_v[~winner] = $urandom_range(0, 1) == 1;
            REQ = req_v;
            if (req_v == 2'b00) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge CLK);
                    check_idle("gap");
                end
                req_v = 2'($urandom_range(1, 3));
                REQ   = req_v;
            end
            mode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            k    = int'($urandom_range(0, 8));
            s    = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) s[3:0] = 4'hF;
            serve(mode, k, s);
        end

        REQ = 2'b00;
        repeat (3) @(negedge CLK);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
